// File: rtl/piece_bag_queue_pkg.sv
// Shared types and constants for the 7-bag piece queue.
// Piece IDs, bag mask limits and the fill/hold state encoding.
package piece_bag_queue_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t     PIECE_NONE = 3'd0;
  localparam int         NUM_PIECES = 7;
  localparam logic [6:0] BAG_FULL   = 7'h7F;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } bag_state_e;

  function automatic piece_t lowest_free(
    input logic [6:0] used
  );
    piece_t r;
    r = PIECE_NONE;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!used[i]) r = piece_t'(i + 1);
    end
    return r;
  endfunction

  function automatic logic [6:0] piece_bit(
    input piece_t p
  );
    return (p == PIECE_NONE) ? 7'd0 :
           (7'd1 << (p - 3'd1));
  endfunction

endpackage

// File: rtl/piece_shift_fifo.sv
// Shift-toward-head lookahead queue of piece IDs.
// Empty slots always hold PIECE_NONE so outputs read 0.
module piece_shift_fifo
  import piece_bag_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [2:0]             push_data,
  output logic [2:0]             head,
  output logic [3*(DEPTH-1)-1:0] preview,
  output logic [3:0]             count
);

  piece_t     mem_q [DEPTH];
  piece_t     mem_d [DEPTH];
  logic [3:0] count_q, count_d;
  logic [3:0] tail;
  logic       pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != 4'd0);
  assign push_ok = push &&
                   ((count_q < 4'(DEPTH)) || pop_ok);

  // Shift on pop, then drop the new entry at the tail.
  always_comb begin
    mem_d   = mem_q;
    tail    = count_q;
    count_d = count_q;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = PIECE_NONE;
      tail = count_q - 4'd1;
    end
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tail == 4'(i)) mem_d[i] = push_data;
      end
    end
    count_d = count_q + {3'b0, push_ok}
                      - {3'b0, pop_ok};
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PIECE_NONE;
      end
      count_q <= 4'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  // Flatten preview slots, entry 1 in the low bits.
  always_comb begin
    preview = '0;
    for (int i = 1; i < DEPTH; i++) begin
      preview[3*(i-1) +: 3] = mem_q[i];
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/piece_bag_queue.sv
// 7-bag filter over a raw 3-bit random stream.
// Feeds a lookahead queue served by request pulses.
module piece_bag_queue
  import piece_bag_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_TRIES = 15
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [2:0]             rng_data,
  input  logic                   piece_req,
  output logic [2:0]             piece_out,
  output logic                   piece_valid,
  output logic [3*(DEPTH-1)-1:0] preview,
  output logic [3:0]             count,
  output logic [6:0]             bag_used
);

  localparam int RW = $clog2(MAX_TRIES + 1);
  localparam logic [RW-1:0] RETRY_LAST =
    RW'(MAX_TRIES - 1);

  bag_state_e    state_q, state_d;
  logic [6:0]    bag_q, bag_d, bag_new;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0]    cnt;
  logic          pop_ok, draw_en;
  logic          raw_ok, forced, push;
  piece_t        push_data;

  assign pop_ok  = piece_req && (cnt != 4'd0);
  assign draw_en = ((state_q == FILL) &&
                    (cnt < 4'(DEPTH))) || pop_ok;
  assign raw_ok  = (rng_data != PIECE_NONE) &&
                   ((bag_q & piece_bit(rng_data)) == 7'd0);
  assign forced  = draw_en && !raw_ok &&
                   (retry_q == RETRY_LAST);
  assign push    = draw_en && (raw_ok || forced);
  assign push_data = raw_ok ? rng_data
                            : lowest_free(bag_q);

  // Bag mask, retry counter and fill/hold next state.
  always_comb begin
    bag_d   = bag_q;
    retry_d = retry_q;
    state_d = state_q;
    bag_new = bag_q | piece_bit(push_data);
    if (push) begin
      bag_d   = (bag_new == BAG_FULL) ? 7'd0 : bag_new;
      retry_d = '0;
    end else if (draw_en) begin
      retry_d = retry_q + 1'b1;
    end
    if (pop_ok) begin
      state_d = FILL;
    end else if (push &&
                 (cnt + 4'd1 == 4'(DEPTH))) begin
      state_d = HOLD;
    end else if (cnt == 4'(DEPTH)) begin
      state_d = HOLD;
    end
  end

  // Control state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FILL;
      bag_q   <= 7'd0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      bag_q   <= bag_d;
      retry_q <= retry_d;
    end
  end

  piece_shift_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (push),
    .pop      (pop_ok),
    .push_data(push_data),
    .head     (piece_out),
    .preview  (preview),
    .count    (cnt)
  );

  assign piece_valid = (cnt != 4'd0);
  assign count       = cnt;
  assign bag_used    = bag_q;

endmodule

// File: tb/tb_piece_bag_queue.sv
// Randomized bench for piece_bag_queue against a queue model.
// Directed scenarios first, then random draws and requests.
module tb_piece_bag_queue;

  localparam int DEPTH     = 4;
  localparam int MAX_TRIES = 15;
  localparam int PW        = 3 * (DEPTH - 1);

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [2:0]    rng_data = 3'd0;
  logic          piece_req = 1'b0;
  logic [2:0]    piece_out;
  logic          piece_valid;
  logic [PW-1:0] preview;
  logic [3:0]    count;
  logic [6:0]    bag_used;

  int checks = 0;
  int errors = 0;

  int m_q[$];
  int m_used;
  int m_retry;

  piece_bag_queue #(
    .DEPTH    (DEPTH),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .rng_data   (rng_data),
    .piece_req  (piece_req),
    .piece_out  (piece_out),
    .piece_valid(piece_valid),
    .preview    (preview),
    .count      (count),
    .bag_used   (bag_used)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int m_preview();
    int p = 0;
    for (int i = 1; i < DEPTH; i++) begin
      if (i < m_q.size()) p |= m_q[i] << (3 * (i - 1));
    end
    return p;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".count"}, int'(count), m_q.size());
    chk({tag, ".valid"}, int'(piece_valid),
        (m_q.size() > 0) ? 1 : 0);
    chk({tag, ".head"}, int'(piece_out),
        (m_q.size() > 0) ? m_q[0] : 0);
    chk({tag, ".preview"}, int'(preview), m_preview());
    chk({tag, ".bag"}, int'(bag_used), m_used);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_used  = 0;
    m_retry = 0;
  endtask

  task automatic model_push(input int v);
    m_q.push_back(v);
    m_used |= 1 << (v - 1);
    if (m_used == 127) m_used = 0;
    m_retry = 0;
  endtask

  task automatic model_edge(input int rng, input bit req);
    bit pop  = req && (m_q.size() > 0);
    bit room = (m_q.size() < DEPTH) || pop;
    if (pop) void'(m_q.pop_front());
    if (room) begin
      if (rng != 0 && ((m_used >> (rng - 1)) & 1) == 0) begin
        model_push(rng);
      end else if (m_retry + 1 == MAX_TRIES) begin
        for (int id = 1; id <= 7; id++) begin
          if (((m_used >> (id - 1)) & 1) == 0) begin
            model_push(id);
            break;
          end
        end
      end else begin
        m_retry++;
      end
    end
  endtask

  task automatic step(input int rng, input bit req);
    rng_data  = rng[2:0];
    piece_req = req;
    @(posedge Clk);
    model_edge(rng, req);
    #1;
    compare_all("step");
  endtask

  task automatic do_reset();
    rng_data  = 3'd0;
    piece_req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    int seq1[5];
    int seq2[5];
    seq1 = '{3, 3, 0, 5, 1};
    seq2 = '{1, 2, 3, 4, 6};

    do_reset();
    foreach (seq1[i]) step(seq1[i], 1'b0);
    chk("fill.count", int'(count), 3);
    chk("fill.head", int'(piece_out), 3);
    chk("fill.prev", int'(preview), (1 << 3) | 5);
    chk("fill.bag", int'(bag_used), 7'b0010101);

    do_reset();
    foreach (seq2[i]) step(seq2[i], 1'b0);
    step(6, 1'b0);
    chk("hold.count", int'(count), 4);
    chk("hold.bag", int'(bag_used), 7'b0001111);
    chk("hold.state", int'(dut.state_q), 1);

    step(6, 1'b1);
    chk("pp.head", int'(piece_out), 2);
    chk("pp.prev", int'(preview),
        (6 << 6) | (4 << 3) | 3);
    chk("pp.count", int'(count), 4);

    do_reset();
    for (int v = 1; v <= 7; v++) step(v, 1'b1);
    chk("roll.bag0", int'(bag_used), 0);
    step(7, 1'b1);
    chk("roll.new7", int'(bag_used), 7'b1000000);
    chk("roll.head", int'(piece_out), 7);

    do_reset();
    for (int v = 1; v <= 6; v++) step(v, 1'b1);
    chk("starve.mask", int'(bag_used), 7'b0111111);
    for (int i = 0; i < MAX_TRIES - 1; i++) step(2, 1'b1);
    chk("starve.wait", int'(count), 0);
    step(2, 1'b1);
    chk("starve.head", int'(piece_out), 7);
    chk("starve.bag", int'(bag_used), 0);

    do_reset();
    for (int v = 1; v <= 3; v++) step(v, 1'b0);
    chk("ar.pre", int'(count), 3);
    #2;
    Reset = 1'b1;
    #1;
    chk("ar.count", int'(count), 0);
    chk("ar.valid", int'(piece_valid), 0);
    model_reset();
    compare_all("ar");
    @(negedge Clk);
    Reset = 1'b0;
    step(0, 1'b1);
    chk("empty.count", int'(count), 0);
    chk("empty.head", int'(piece_out), 0);

    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      if ($urandom_range(0, 3) == 0) r = 0;
      else r = $urandom_range(1, 7);
      if (n % 150 < 20) r = 4;
      step(r, $urandom_range(0, 9) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
